// File: rtl/delay_timer_pkg.sv
// Shared constants for the delay timer bank: channel states, mode encodings and
// the prescaler width helper.
package delay_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Counter width able to hold 0..div-1; never narrower than one bit.
   function automatic int prescaler_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: emits a registered one-cycle tick every TICK_DIV clocks,
// in the cycle after the counter wraps.
module tick_prescaler #(
   parameter int TICK_DIV = 500000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);
   import delay_timer_pkg::*;

   localparam int            PW   = prescaler_width(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else if (pcnt == LAST) begin
         pcnt <= '0;
         tick <= 1'b1;
      end else begin
         pcnt <= pcnt + PW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NUM_CH independent programmable delay timers sharing one prescaler tick.
// Each channel is one-shot or periodic and reports expiry as a level and a strobe.
module delay_timer_bank #(
   parameter int NUM_CH   = 2,
   parameter int DLY_W    = 8,
   parameter int TICK_DIV = 500000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_CH-1:0]         start,
   input  logic [NUM_CH-1:0]         enable,
   input  logic [NUM_CH-1:0]         periodic,
   input  logic [NUM_CH*DLY_W-1:0]   delay,
   output logic [NUM_CH-1:0]         done,
   output logic [NUM_CH-1:0]         done_pulse,
   output logic [NUM_CH-1:0]         busy,
   output logic                      tick
);
   import delay_timer_pkg::*;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t        state_q, state_nxt;
      logic [DLY_W-1:0] cnt_q, cnt_nxt;
      logic [DLY_W-1:0] dly_q, dly_nxt;
      logic             mode_q, mode_nxt;
      logic             done_q, done_nxt;
      logic             pulse_q, pulse_nxt;
      logic [DLY_W-1:0] delay_slice;

      assign delay_slice = delay[i*DLY_W +: DLY_W];

      // Priority is enable-low, then start, then the tick; start still latches
      // its settings while the channel is disabled.
      always_comb begin
         state_nxt = state_q;
         cnt_nxt   = cnt_q;
         dly_nxt   = dly_q;
         mode_nxt  = mode_q;
         done_nxt  = done_q;
         pulse_nxt = 1'b0;

         if (!enable[i]) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            if (start[i]) begin
               dly_nxt  = delay_slice;
               mode_nxt = periodic[i];
            end
         end else if (start[i]) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            dly_nxt   = delay_slice;
            mode_nxt  = periodic[i];
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end
               ST_RUN: begin
                  if (tick) begin
                     if (cnt_q == dly_q) begin
                        pulse_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
                     end else begin
                        cnt_nxt = cnt_q + DLY_W'(1);
                     end
                  end
               end
               ST_DONE: begin
                  state_nxt = ST_DONE;
               end
               default: begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            dly_q   <= dly_nxt;
            mode_q  <= mode_nxt;
            done_q  <= done_nxt;
            pulse_q <= pulse_nxt;
         end
      end

      assign done[i]       = done_q;
      assign done_pulse[i] = pulse_q;
      assign busy[i]       = (state_q == ST_RUN);
   end

endmodule
